sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter that shares one port of a 16-bit × 16384-word on-chip SRAM between two Avalon-MM style masters, such as the NPU compute engine and the weight/activation loader. It selects one requester per cycle with hold-limited round-robin, drives the SRAM port signals (chipselect, write, address, byteenable, writedata), and returns read data with a per-requester `readdatavalid`. The block sits between the masters and one port of the dual-port SRAM. The other SRAM port is untouched.

## Interface
Parameters:
- `MAX_HOLD`, default 4: consecutive accepted accesses the current owner may make while the other requester waits. Legal range 1–15.
- `ADDR_W`, default 14: word address width.
- `DATA_W`, default 16: data width. `DATA_W/8` byteenable bits.

Ports:
- `clk`  in  1: the single clock for all logic.
- `reset`  in  1: asynchronous, active-high reset.
- `mN_address`  in  ADDR_W: word address (N = 0, 1).
- `mN_read`, `mN_write`  in  1 each: request strobes.
- `mN_writedata`  in  DATA_W: write data.
- `mN_byteenable`  in  DATA_W/8: byte lanes.
- `mN_waitrequest`  out  1: request not accepted this cycle.
- `mN_readdata`  out  DATA_W: read data.
- `mN_readdatavalid`  out  1: `mN_readdata` is valid this cycle.
- `sram_chipselect`, `sram_write`  out  1 each: SRAM port controls.
- `sram_address`  out  ADDR_W: SRAM port address.
- `sram_byteenable`  out  DATA_W/8: SRAM port byte lanes.
- `sram_writedata`  out  DATA_W: SRAM port write data.
- `sram_readdata`  in  DATA_W: SRAM port read data. The SRAM has registered address and unregistered q, so read latency is 1 cycle.

## Operation
- `reqN = mN_read | mN_write`. If `mN_read` and `mN_write` are both high, the access is a write and the read is ignored.
- State: `owner` (1 bit, reset 0) and `hold_cnt` (saturating, reset 0).
- Grant is combinational:
  - Only one requester active: it wins.
  - Both active: `owner` wins while `hold_cnt < MAX_HOLD`, otherwise `~owner` wins.
  - Neither active: no grant.
- `mN_waitrequest = reqN & ~grantN`. The signal is low whenever the requester is idle.
- An access is accepted when `reqN & grantN`.
- On acceptance by g:
  - If g == owner: `hold_cnt <= min(hold_cnt+1, MAX_HOLD)`.
  - Otherwise: `owner <= g`, `hold_cnt <= 1`.
- Idle cycles do not change `owner` or `hold_cnt`.
- SRAM side follows the winner's signals combinationally:
  - `sram_chipselect` = any grant.
  - `sram_write` = winner's write.
  - `sram_address`, `sram_byteenable`, `sram_writedata` come from the winner.
  - With no grant, the data and address outputs are driven 0.
- Read tracking:
  - Registers `rd_pend` (reset 0) and `rd_tag` (reset 0) capture "accepted read" and the winner index on each accepted read.
  - `mN_readdatavalid = rd_pend & (rd_tag == N)`.
- `mN_readdata = sram_readdata` for both requesters. It is qualified only by `readdatavalid`.
- Masters must hold their request signals stable while `waitrequest` is high. The arbiter does not check this.

## Timing
- Throughput is one access per cycle. Back-to-back accesses from different requesters need no bubble.
- Write: completes in the accept cycle, with no response.
- Read accepted in cycle T: `readdatavalid` is high in cycle T+1 with the data at that address. Pipelined reads each get valid exactly 1 cycle after acceptance.
- Read-during-write to the same address from the other SRAM port is undefined (mixed-port don't-care). Masters must avoid it.
- Reset values while `reset` is high:
  - `sram_*` outputs: 0.
  - `mN_readdatavalid`: 0.
  - `mN_waitrequest`: follows `reqN`, because grant is suppressed during reset.
- Reset asserted with a read in flight: the pending `readdatavalid` is dropped and never emitted.
- First contention after reset: m0 wins.
- With `MAX_HOLD=1`, both requesters alternate every cycle under continuous contention.

## Structure
- Shared package `npu_sram_pkg` holds:
  - `SRAM_ADDR_W=14`, `SRAM_DATA_W=16`, `SRAM_BE_W=2`.
  - `typedef` of the requester index.
  - A request struct {addr, be, wdata, rd, wr}.
- One natural sub-module: `rr_hold_grant`, which contains the owner/hold_cnt state and the grant logic. The top level keeps the muxing and read tagging.

## Test plan
- Reset, then m0 reads 0x0005 with m1 idle: accept in T with `m0_waitrequest` low, `m0_readdatavalid` at T+1 with the preloaded value, `m1_readdatavalid` stays 0.
- m1 writes 0xBEEF to 0x1234 with be=2'b10, then reads it back: SRAM holds 0xBEXX (upper byte only), and the read returns it at accept+1 on m1.
- Both requesters stream reads continuously, `MAX_HOLD=4`: grant sequence is m0×4, m1×4, m0×4. Each `readdatavalid` appears on the correct requester with the matching data.
- `MAX_HOLD=1`, both requesting: grants alternate m0, m1, m0, with no idle cycles on `sram_chipselect`.
- m0 reads 0x0010 in T, and `reset` pulses in T+1: no `readdatavalid` appears after reset. The next contention grants m0 first.
- m0 asserts read and write together to 0x0020 with data 0x00AA: a write occurs and no `readdatavalid` follows.

Source files
------------

// File: rtl/npu_sram_pkg.sv
// npu_sram_pkg: shared SRAM geometry, requester index and request record for the NPU SRAM port blocks
package npu_sram_pkg;
  localparam int SRAM_ADDR_W = 14;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_BE_W = 2;
  typedef logic req_idx_t;
  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_BE_W-1:0] be;
    logic [SRAM_DATA_W-1:0] wdata;
    logic rd;
    logic wr;
  } sram_req_t;
endpackage

// File: rtl/rr_hold_grant.sv
// rr_hold_grant: two-way hold-limited round-robin grant with owner/hold counter state
module rr_hold_grant import npu_sram_pkg::*; #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output req_idx_t   win
);
  localparam logic [3:0] MAX = 4'(MAX_HOLD);
  req_idx_t owner;
  logic [3:0] hold_cnt;
  always_comb begin
    win = (req[0] & req[1]) ? ((hold_cnt < MAX) ? owner : ~owner) : req[1];
    grant = (reset | ~|req) ? 2'b00 : (win ? 2'b10 : 2'b01);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= 1'b0;
      hold_cnt <= '0;
    end else if (|grant) begin
      owner <= win;
      hold_cnt <= (win != owner) ? 4'd1 : (hold_cnt == MAX) ? MAX : hold_cnt + 4'd1;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between two Avalon-MM masters with tagged 1-cycle read returns
module sram_port_arbiter import npu_sram_pkg::*; #(
  parameter int MAX_HOLD = 4,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic [DATA_W-1:0]   sram_writedata,
  input  logic [DATA_W-1:0]   sram_readdata
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0] wdata;
    logic rd;
    logic wr;
  } req_t;
  req_t r0, r1, sel;
  logic [1:0] grant;
  req_idx_t win, rd_tag;
  logic rd_pend, rd_accept;
  // write wins when a master raises read and write together
  assign r0 = '{addr: m0_address, be: m0_byteenable, wdata: m0_writedata, rd: m0_read & ~m0_write, wr: m0_write};
  assign r1 = '{addr: m1_address, be: m1_byteenable, wdata: m1_writedata, rd: m1_read & ~m1_write, wr: m1_write};
  rr_hold_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
    .clk(clk),
    .reset(reset),
    .req({m1_read | m1_write, m0_read | m0_write}),
    .grant(grant),
    .win(win)
  );
  always_comb begin
    sel = win ? r1 : r0;
    sram_chipselect = |grant;
    sram_write = sram_chipselect & sel.wr;
    sram_address = sram_chipselect ? sel.addr : '0;
    sram_byteenable = sram_chipselect ? sel.be : '0;
    sram_writedata = sram_chipselect ? sel.wdata : '0;
    rd_accept = sram_chipselect & sel.rd;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_pend <= 1'b0;
      rd_tag <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_tag <= win;
    end
  assign m0_waitrequest = (m0_read | m0_write) & ~grant[0];
  assign m1_waitrequest = (m1_read | m1_write) & ~grant[1];
  assign m0_readdatavalid = rd_pend & (rd_tag == 1'b0);
  assign m1_readdatavalid = rd_pend & (rd_tag == 1'b1);
  assign m0_readdata = sram_readdata;
  assign m1_readdata = sram_readdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of the SRAM port arbiter against an SRAM model
module tb_sram_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [13:0] m0_address, m1_address, sram_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, sram_writedata, sram_readdata;
  logic [1:0] m0_byteenable, m1_byteenable, sram_byteenable;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, sram_chipselect, sram_write;
  logic [13:0] b_m0_address, b_m1_address, b_sram_address;
  logic b_m0_read, b_m0_write, b_m1_read, b_m1_write;
  logic [15:0] b_m0_readdata, b_m1_readdata, b_sram_writedata, b_sram_readdata;
  logic [1:0] b_sram_byteenable;
  logic b_m0_waitrequest, b_m1_waitrequest, b_m0_readdatavalid, b_m1_readdatavalid, b_sram_chipselect, b_sram_write;
  int pass_cnt = 0, total = 0;

  sram_port_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write), .sram_address(sram_address),
    .sram_byteenable(sram_byteenable), .sram_writedata(sram_writedata), .sram_readdata(sram_readdata)
  );

  sram_port_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .clk(clk), .reset(reset),
    .m0_address(b_m0_address), .m0_read(b_m0_read), .m0_write(b_m0_write), .m0_writedata(16'h0),
    .m0_byteenable(2'b11), .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
    .m0_readdatavalid(b_m0_readdatavalid),
    .m1_address(b_m1_address), .m1_read(b_m1_read), .m1_write(b_m1_write), .m1_writedata(16'h0),
    .m1_byteenable(2'b11), .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
    .m1_readdatavalid(b_m1_readdatavalid),
    .sram_chipselect(b_sram_chipselect), .sram_write(b_sram_write), .sram_address(b_sram_address),
    .sram_byteenable(b_sram_byteenable), .sram_writedata(b_sram_writedata), .sram_readdata(b_sram_readdata)
  );
  assign b_sram_readdata = 16'h0;

  // SRAM model: registered address, unregistered q, byte-lane writes, bench-side preload port
  logic [15:0] mem [0:16383];
  logic [13:0] addr_q = '0;
  logic pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_chipselect && sram_write) begin
      if (sram_byteenable[0]) mem[sram_address][7:0] <= sram_writedata[7:0];
      if (sram_byteenable[1]) mem[sram_address][15:8] <= sram_writedata[15:8];
    end
    if (sram_chipselect && !sram_write) addr_q <= sram_address;
  end
  assign sram_readdata = mem[addr_q];

  task automatic idle;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 2'b11; m1_byteenable = 2'b11;
    b_m0_read = 0; b_m0_write = 0; b_m1_read = 0; b_m1_write = 0;
    b_m0_address = '0; b_m1_address = '0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [15:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    @(posedge clk); #1 pl_en = 0;
  endtask

  task automatic do_reset;
    idle;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_reset;
    idle;
    m0_read = 1; m0_address = 14'h0033; m1_write = 1; m1_address = 14'h0044; m1_writedata = 16'h1234;
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b1) $display("FAIL rst_m0_wait got %b exp 1", m0_waitrequest); else pass_cnt++;
    total++; if (m1_waitrequest !== 1'b1) $display("FAIL rst_m1_wait got %b exp 1", m1_waitrequest); else pass_cnt++;
    total++; if ({sram_chipselect, sram_write} !== 2'b00) $display("FAIL rst_ctrl got %b exp 00", {sram_chipselect, sram_write}); else pass_cnt++;
    total++; if ({sram_address, sram_writedata, sram_byteenable} !== 32'h0) $display("FAIL rst_bus got %h exp 0", {sram_address, sram_writedata, sram_byteenable}); else pass_cnt++;
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL rst_rdv got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    @(posedge clk); #1 idle;
    preload(14'h0005, 16'h1111);
    preload(14'h1234, 16'h5678);
    preload(14'h0010, 16'h7777);
    for (int i = 0; i < 8; i++) begin
      preload(14'(32'h100 + i), 16'(32'hA000 + i));
      preload(14'(32'h200 + i), 16'(32'hB000 + i));
    end
    do_reset;
  endtask

  task automatic test_single_read;
    m0_read = 1; m0_address = 14'h0005;
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b0) $display("FAIL rd_accept_wait got %b exp 0", m0_waitrequest); else pass_cnt++;
    total++; if ({sram_chipselect, sram_write, sram_address} !== {2'b10, 14'h0005}) $display("FAIL rd_sram got cs=%b we=%b a=%h exp 1 0 0005", sram_chipselect, sram_write, sram_address); else pass_cnt++;
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rd_early_rdv got %b exp 0", m0_readdatavalid); else pass_cnt++;
    @(posedge clk); #1 idle;
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 16'h1111) $display("FAIL rd_data got v=%b d=%h exp 1 1111", m0_readdatavalid, m0_readdata); else pass_cnt++;
    total++; if (m1_readdatavalid !== 1'b0) $display("FAIL rd_m1_rdv got %b exp 0", m1_readdatavalid); else pass_cnt++;
    total++; if ({m0_waitrequest, m1_waitrequest, sram_chipselect, sram_address} !== 17'h0) $display("FAIL idle_outputs got %h exp 0", {m0_waitrequest, m1_waitrequest, sram_chipselect, sram_address}); else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL rd_single_pulse got %b exp 0", m0_readdatavalid); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_be;
    m1_write = 1; m1_address = 14'h1234; m1_writedata = 16'hBEEF; m1_byteenable = 2'b10;
    @(negedge clk);
    total++; if (m1_waitrequest !== 1'b0) $display("FAIL wr_wait got %b exp 0", m1_waitrequest); else pass_cnt++;
    total++; if ({sram_write, sram_byteenable, sram_writedata, sram_address} !== {1'b1, 2'b10, 16'hBEEF, 14'h1234}) $display("FAIL wr_bus got we=%b be=%b d=%h a=%h exp 1 10 beef 1234", sram_write, sram_byteenable, sram_writedata, sram_address); else pass_cnt++;
    @(posedge clk); #1 idle;
    m1_read = 1; m1_address = 14'h1234;
    @(negedge clk);
    total++; if ({m1_waitrequest, m1_readdatavalid} !== 2'b00) $display("FAIL wr_rd_accept got %b exp 00", {m1_waitrequest, m1_readdatavalid}); else pass_cnt++;
    @(posedge clk); #1 idle;
    @(negedge clk);
    total++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 16'hBE78) $display("FAIL wr_readback got v=%b d=%h exp 1 be78", m1_readdatavalid, m1_readdata); else pass_cnt++;
    total++; if (m0_readdatavalid !== 1'b0) $display("FAIL wr_m0_rdv got %b exp 0", m0_readdatavalid); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    int n0, n1, w, pw;
    logic [15:0] pd;
    n0 = 0; n1 = 0; pw = -1; pd = '0;
    m0_read = 1; m1_read = 1;
    for (int i = 0; i < 12; i++) begin
      m0_address = 14'(32'h100 + n0);
      m1_address = 14'(32'h200 + n1);
      w = (i / 4) % 2;
      @(negedge clk);
      total++; if ({m0_waitrequest, m1_waitrequest} !== {w == 1, w == 0}) $display("FAIL stream_grant c%0d got wait=%b%b exp winner m%0d", i, m0_waitrequest, m1_waitrequest, w); else pass_cnt++;
      total++; if (sram_address !== (w == 1 ? m1_address : m0_address)) $display("FAIL stream_addr c%0d got %h", i, sram_address); else pass_cnt++;
      if (pw >= 0) begin
        total++; if ({m0_readdatavalid, m1_readdatavalid} !== {pw == 0, pw == 1} || (pw == 1 ? m1_readdata : m0_readdata) !== pd) $display("FAIL stream_rdv c%0d got v=%b%b d=%h exp m%0d %h", i, m0_readdatavalid, m1_readdatavalid, sram_readdata, pw, pd); else pass_cnt++;
      end
      pd = (w == 1) ? 16'(32'hB000 + n1) : 16'(32'hA000 + n0);
      pw = w;
      if (w == 1) n1++; else n0++;
      @(posedge clk); #1;
    end
    idle;
    @(negedge clk);
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== {pw == 0, pw == 1} || m0_readdata !== pd) $display("FAIL stream_last got v=%b%b d=%h exp %h", m0_readdatavalid, m1_readdatavalid, m0_readdata, pd); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_hold1;
    b_m0_read = 1; b_m1_read = 1; b_m0_address = 14'h0001; b_m1_address = 14'h0002;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if ({b_sram_chipselect, b_m0_waitrequest, b_m1_waitrequest} !== {1'b1, i % 2 == 1, i % 2 == 0}) $display("FAIL hold1 c%0d got cs=%b wait=%b%b exp winner m%0d", i, b_sram_chipselect, b_m0_waitrequest, b_m1_waitrequest, i % 2); else pass_cnt++;
      @(posedge clk); #1;
    end
    idle;
  endtask

  task automatic test_reset_inflight;
    m0_read = 1; m0_address = 14'h0010;
    @(negedge clk);
    total++; if ({m0_waitrequest, sram_address} !== {1'b0, 14'h0010}) $display("FAIL inflight_accept got w=%b a=%h exp 0 0010", m0_waitrequest, sram_address); else pass_cnt++;
    @(posedge clk); #1 idle;
    reset = 1;
    @(negedge clk);
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL inflight_drop got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL inflight_after c%0d got %b exp 00", i, {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
      @(posedge clk); #1;
    end
    m0_read = 1; m1_read = 1; m0_address = 14'h0005; m1_address = 14'h0006;
    @(negedge clk);
    total++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) $display("FAIL inflight_first_grant got %b exp 01", {m0_waitrequest, m1_waitrequest}); else pass_cnt++;
    @(posedge clk); #1 idle;
    @(posedge clk); #1;
  endtask

  task automatic test_rw_both;
    m0_read = 1; m0_write = 1; m0_address = 14'h0020; m0_writedata = 16'h00AA;
    @(negedge clk);
    total++; if ({m0_waitrequest, sram_write, sram_writedata, sram_address} !== {2'b01, 16'h00AA, 14'h0020}) $display("FAIL rw_write got w=%b we=%b d=%h a=%h exp 0 1 00aa 0020", m0_waitrequest, sram_write, sram_writedata, sram_address); else pass_cnt++;
    @(posedge clk); #1 idle;
    @(negedge clk);
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) $display("FAIL rw_no_rdv got %b exp 00", {m0_readdatavalid, m1_readdatavalid}); else pass_cnt++;
    @(posedge clk); #1;
    m0_read = 1; m0_address = 14'h0020;
    @(posedge clk); #1 idle;
    @(negedge clk);
    total++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 16'h00AA) $display("FAIL rw_readback got v=%b d=%h exp 1 00aa", m0_readdatavalid, m0_readdata); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_write_be;
    do_reset;
    test_stream;
    do_reset;
    test_hold1;
    test_reset_inflight;
    test_rw_both;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
